// File: rtl/dma_read_arbiter_rr.sv
// N-path arbiter in front of a single DMA read engine: round-robin or fixed-priority grant,
// registered request onto the engine, one-cycle done/err pulse back to the granted path.
module dma_read_arbiter_rr #(
    parameter int P_PATHS   = 2,
    parameter int P_ADDR_W  = 32,
    parameter int P_LEN_W   = 10,
    parameter int P_MODE    = 0,
    parameter int P_TIMEOUT = 0,
    parameter int P_TMO_W   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [P_PATHS*P_ADDR_W-1:0]   ar_dma_read_addr,
    input  logic [P_PATHS*P_LEN_W-1:0]    ar_dma_read_len,
    input  logic [P_PATHS-1:0]            ar_dma_read_valid,
    output logic [P_PATHS-1:0]            ar_dma_done,
    output logic [P_PATHS-1:0]            ar_dma_err,
    output logic [P_ADDR_W-1:0]           dma_read_addr,
    output logic [P_LEN_W-1:0]            dma_read_len,
    output logic                          dma_valid,
    input  logic                          dma_done,
    output logic                          o_busy,
    output logic [$clog2(P_PATHS)-1:0]    o_grant_idx
);

    localparam int IDX_W = $clog2(P_PATHS);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(P_PATHS - 1);
    localparam logic [IDX_W:0]     PATHS_EXT = (IDX_W + 1)'(P_PATHS);
    localparam logic [P_TMO_W-1:0] TMO_LAST  = P_TMO_W'(P_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [P_TMO_W-1:0]   wdog_q, wdog_d;
    logic [P_ADDR_W-1:0]  addr_q, addr_d;
    logic [P_LEN_W-1:0]   len_q, len_d;
    logic                 valid_q, valid_d;
    logic [P_PATHS-1:0]   done_q, done_d;
    logic [P_PATHS-1:0]   err_q, err_d;

    logic [P_ADDR_W-1:0]  req_addr [P_PATHS];
    logic [P_LEN_W-1:0]   req_len  [P_PATHS];

    for (genvar j = 0; j < P_PATHS; j++) begin : g_unpack
        assign req_addr[j] = ar_dma_read_addr[j*P_ADDR_W +: P_ADDR_W];
        assign req_len[j]  = ar_dma_read_len[j*P_LEN_W +: P_LEN_W];
    end

    logic [IDX_W-1:0] search_base;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    // Fixed priority is a cyclic search that always starts just after the last index.
    always_comb begin
        search_base = (P_MODE == 1) ? LAST_IDX : ptr_q;
        cand_sum    = '0;
        win_idx     = '0;
        win_found   = 1'b0;
        // Walk backwards so the last hit is the first path in cyclic order.
        for (int k = P_PATHS; k >= 1; k--) begin
            cand_sum = {1'b0, search_base} + (IDX_W + 1)'(k);
            if (cand_sum >= PATHS_EXT) begin
                cand_sum = cand_sum - PATHS_EXT;
            end
            if (ar_dma_read_valid[cand_sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // NOTE: every _d starts from its _q (or zero for pulses) so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        addr_d  = addr_q;
        len_d   = len_q;
        valid_d = valid_q;
        done_d  = '0;
        err_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    addr_d  = req_addr[win_idx];
                    len_d   = req_len[win_idx];
                    valid_d = 1'b1;
                    grant_d = win_idx;
                    wdog_d  = '0;
                    if (P_MODE == 0) begin
                        ptr_d = win_idx;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dma_done) begin
                    valid_d          = 1'b0;
                    done_d[grant_q]  = 1'b1;
                    state_d          = ST_RELEASE;
                end else if (P_TIMEOUT != 0 && wdog_q == TMO_LAST) begin
                    valid_d          = 1'b0;
                    err_d[grant_q]   = 1'b1;
                    state_d          = ST_RELEASE;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block above.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= LAST_IDX;
            grant_q <= '0;
            wdog_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dma_read_addr = addr_q;
    assign dma_read_len  = len_q;
    assign dma_valid     = valid_q;
    assign ar_dma_done   = done_q;
    assign ar_dma_err    = err_q;
    assign o_grant_idx   = grant_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule
